// File: rtl/unpacked_array_deser.sv
// Serial-to-parallel deserializer: packs single-bit beats into M-entry unpacked frames,
// double-buffered (assembly buffer + output register) with sticky overrun on dropped frames.
module unpacked_array_deser #(
  parameter int M     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic             q [M],
  output logic             q_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(M - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             asm_buf   [M];
  logic             new_frame [M];
  logic             done;
  logic             handshake;
  logic             drop;
  logic             load;

  // The completing frame must include the bit arriving this very cycle.
  always_comb begin
    done = sin_valid && (idx == LAST);
    for (int i = 0; i < M; i++) begin
      new_frame[i] = (i == int'(idx)) ? sin : asm_buf[i];
    end
  end

  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    drop      = 1'b0;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          handshake = 1'b1;
          if (done) load = 1'b1;
          else      state_nxt = EMPTY;
        end else if (done) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      idx       <= '0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < M; i++) begin
        asm_buf[i] <= 1'b0;
        q[i]       <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      if (sin_valid) begin
        idx <= done ? '0 : idx + 1'b1;
        for (int i = 0; i < M; i++) begin
          if (i == int'(idx)) asm_buf[i] <= sin;
        end
      end
      if (load) begin
        for (int i = 0; i < M; i++) q[i] <= new_frame[i];
      end
      if (handshake) frame_cnt <= frame_cnt + 1'b1;
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  assign q_valid = (state == FULL);

endmodule

// File: tb/tb_unpacked_array_deser.sv
// Bench: three deserializers (M=2/CNT_W=8, M=2/CNT_W=2, M=1/CNT_W=4) on shared stimulus,
// checked every cycle against a queue-based frame model plus hand-computed literals.
module tb_unpacked_array_deser;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;

  logic       qa [2];
  logic       qb [2];
  logic       qc [1];
  logic       va, vb, vc, oa, ob, oc;
  logic [7:0] ca;
  logic [1:0] cb;
  logic [3:0] cc;

  int nvec  = 0;
  int nfail = 0;
  bit started = 1'b0;

  always #5 clock = ~clock;

  unpacked_array_deser #(.M(2), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .sin(sin), .sin_valid(sin_valid), .out_ready(out_ready),
    .clr_ovr(clr_ovr), .q(qa), .q_valid(va), .overrun(oa), .frame_cnt(ca));
  unpacked_array_deser #(.M(2), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .sin(sin), .sin_valid(sin_valid), .out_ready(out_ready),
    .clr_ovr(clr_ovr), .q(qb), .q_valid(vb), .overrun(ob), .frame_cnt(cb));
  unpacked_array_deser #(.M(1), .CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .sin(sin), .sin_valid(sin_valid), .out_ready(out_ready),
    .clr_ovr(clr_ovr), .q(qc), .q_valid(vc), .overrun(oc), .frame_cnt(cc));

  // Model: bits collect in a queue; a full queue is a frame that either lands in the
  // output slot (if empty or being consumed this cycle) or is dropped.
  bit pend2[$];
  bit eq2 [2];
  bit ev2, eo2, done2, drop2;
  int ef2;
  bit eq1, ev1, eo1, drop1;
  int ef1;

  always @(posedge clock) begin
    if (reset) begin
      started = 1'b1;
      pend2.delete();
      eq2[0] = 1'b0; eq2[1] = 1'b0;
      ev2 = 1'b0; eo2 = 1'b0; ef2 = 0;
      eq1 = 1'b0; ev1 = 1'b0; eo1 = 1'b0; ef1 = 0;
    end else begin
      done2 = 1'b0; drop2 = 1'b0; drop1 = 1'b0;
      if (sin_valid) begin
        pend2.push_back(sin);
        done2 = (pend2.size() == 2);
      end
      if (ev2 && out_ready) begin ef2++; ev2 = 1'b0; end
      if (done2) begin
        if (ev2) drop2 = 1'b1;
        else begin eq2[0] = pend2[0]; eq2[1] = pend2[1]; ev2 = 1'b1; end
        pend2.delete();
      end
      if (drop2) eo2 = 1'b1; else if (clr_ovr) eo2 = 1'b0;

      if (ev1 && out_ready) begin ef1++; ev1 = 1'b0; end
      if (sin_valid) begin
        if (ev1) drop1 = 1'b1;
        else begin eq1 = sin; ev1 = 1'b1; end
      end
      if (drop1) eo1 = 1'b1; else if (clr_ovr) eo1 = 1'b0;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      chk1("a.q_valid", va, ev2);  chk1("a.q0", qa[0], eq2[0]); chk1("a.q1", qa[1], eq2[1]);
      chk1("a.overrun", oa, eo2);  chkn("a.frame_cnt", 32'(ca), ef2 % 256);
      chk1("b.q_valid", vb, ev2);  chk1("b.q0", qb[0], eq2[0]); chk1("b.q1", qb[1], eq2[1]);
      chk1("b.overrun", ob, eo2);  chkn("b.frame_cnt", 32'(cb), ef2 % 4);
      chk1("c.q_valid", vc, ev1);  chk1("c.q0", qc[0], eq1);
      chk1("c.overrun", oc, eo1);  chkn("c.frame_cnt", 32'(cc), ef1 % 16);
    end
  end

  task automatic cyc(input logic v, input logic s, input logic r, input logic c, input logic rst);
    sin_valid = v; sin = s; out_ready = r; clr_ovr = c; reset = rst;
    @(negedge clock);
  endtask

  logic [9:0] pat;

  initial begin
    // reset dominates active beats
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk1("t1.q0", qa[0], 1'b0); chk1("t1.q1", qa[1], 1'b0);
    chk1("t1.q_valid", va, 1'b0); chk1("t1.overrun", oa, 1'b0);
    chkn("t1.frame_cnt", 32'(ca), 32'd0);

    // basic frame, consumer stalled
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("t2.q_valid", va, 1'b1); chk1("t2.q0", qa[0], 1'b1); chk1("t2.q1", qa[1], 1'b0);
    chk1("t2.m1_q0", qc[0], 1'b1); chk1("t2.m1_overrun", oc, 1'b1);

    // gaps between beats
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk1("t3.q_valid", va, 1'b1); chk1("t3.q0", qa[0], 1'b0); chk1("t3.q1", qa[1], 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk1("t3.q_valid_drop", va, 1'b0); chkn("t3.frame_cnt", 32'(ca), 32'd1);

    // overrun, clear, and drop-beats-clear
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("t4.q_valid", va, 1'b1); chk1("t4.q0", qa[0], 1'b1); chk1("t4.q1", qa[1], 1'b1);
    chk1("t4.overrun", oa, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("t4.overrun_clr", oa, 1'b0); chk1("t4.q_valid_held", va, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("t4.drop_wins", oa, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk1("t4.overrun_clr2", oa, 1'b0); chk1("t4.q_valid_done", va, 1'b0);
    chkn("t4.frame_cnt", 32'(ca), 32'd1);

    // continuous beats, counter wrap on the narrow instance
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pat = 10'b1011001110;
    for (int i = 0; i < 10; i++) cyc(1'b1, pat[i], 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chkn("t5.frame_cnt8", 32'(ca), 32'd5); chkn("t5.frame_cnt2", 32'(cb), 32'd1);
    chk1("t5.overrun", oa, 1'b0); chkn("t5.m1_frame_cnt", 32'(cc), 32'd10);

    // reset mid-frame discards the partial bit
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk1("t6.q_valid", va, 1'b1); chk1("t6.q0", qa[0], 1'b0); chk1("t6.q1", qa[1], 1'b1);

    // mixed traffic against the model
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          (i % 64 < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 9) == 0, i == 200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
